// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_pkg
//  Purpose  : Shared constants for the writeback port arbiter: 2-bit source
//             codes reported on out_src and the default datapath widths.
//  Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_PIPE = 2'b01;
    localparam logic [1:0] SRC_MDU  = 2'b10;
    localparam logic [1:0] SRC_MEM  = 2'b11;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

endpackage
`default_nettype wire

// File: rtl/wb_age_counter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_age_counter
//  Purpose  : Saturating wait counter for one writeback requester. Counts
//             consecutive cycles spent valid but not accepted; flags the
//             requester urgent once the count reaches STARVE_LIMIT.
//  Ports    : clock, reset (async, active-low)
//             i_valid  - requester has a write pending
//             i_ready  - requester was accepted this cycle
//             o_urgent - counter saturated at STARVE_LIMIT
//  Revision : 1.0 - initial release
// ============================================================================
module wb_age_counter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_valid,
    input  logic i_ready,
    output logic o_urgent
);

    localparam int               c_CNT_W = 4;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    logic [c_CNT_W-1:0] r_count;

    // Any gap in the request, or a grant, restarts the wait from zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (!i_valid || i_ready) begin
            r_count <= '0;
        end else if (r_count != c_LIMIT) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_urgent = (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter
//  Purpose  : Shares the register-file write port between the execute pipe,
//             the MDU and the load-return path. Fixed priority mem > pipe >
//             mdu, overridden by starvation aging (urgent beats non-urgent).
//             The winning write is registered, one write per cycle.
//  Ports    : clock, reset (async assert, active-low)
//             {pipe,mdu,mem}_valid/_ready/_regdest/_wbvalue - requesters
//             out_regdest/out_writereg/out_wbvalue - register-file write port
//             out_src - source of the current write (wb_pkg::SRC_*)
//  Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W       = wb_pkg::DATA_W,
    parameter int REG_W        = wb_pkg::REG_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pipe_valid,
    output logic              pipe_ready,
    input  logic [REG_W-1:0]  pipe_regdest,
    input  logic [DATA_W-1:0] pipe_wbvalue,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [REG_W-1:0]  mdu_regdest,
    input  logic [DATA_W-1:0] mdu_wbvalue,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [REG_W-1:0]  mem_regdest,
    input  logic [DATA_W-1:0] mem_wbvalue,
    output logic [REG_W-1:0]  out_regdest,
    output logic              out_writereg,
    output logic [DATA_W-1:0] out_wbvalue,
    output logic [1:0]        out_src
);

    // Requester vector index: 0 = pipe, 1 = mdu, 2 = mem.
    localparam int c_N = 3;

    logic [c_N-1:0] w_valid;
    logic [c_N-1:0] w_ready;
    logic [c_N-1:0] w_urgent;
    logic [c_N-1:0] w_urg_valid;
    logic [c_N-1:0] w_cand;

    logic              w_grant;
    logic [1:0]        w_win_src;
    logic [REG_W-1:0]  w_win_regdest;
    logic [DATA_W-1:0] w_win_wbvalue;

    // Gating with reset keeps every ready low while reset is held.
    assign w_valid = {mem_valid, mdu_valid, pipe_valid} & {c_N{reset}};

    generate
        for (genvar gi = 0; gi < c_N; gi++) begin : g_age
            wb_age_counter #(
                .STARVE_LIMIT (STARVE_LIMIT)
            ) u_age (
                .clock    (clock),
                .reset    (reset),
                .i_valid  (w_valid[gi]),
                .i_ready  (w_ready[gi]),
                .o_urgent (w_urgent[gi])
            );
        end
    endgenerate

    // If anyone is urgent only urgent requesters compete; base priority
    // then decides within whichever class is competing.
    assign w_urg_valid = w_urgent & w_valid;
    assign w_cand      = (|w_urg_valid) ? w_urg_valid : w_valid;

    always_comb begin
        w_ready = '0;
        if (w_cand[2]) begin
            w_ready[2] = 1'b1;
        end else if (w_cand[0]) begin
            w_ready[0] = 1'b1;
        end else if (w_cand[1]) begin
            w_ready[1] = 1'b1;
        end
    end

    assign pipe_ready = w_ready[0];
    assign mdu_ready  = w_ready[1];
    assign mem_ready  = w_ready[2];
    assign w_grant    = |w_ready;

    always_comb begin
        w_win_src     = SRC_NONE;
        w_win_regdest = '0;
        w_win_wbvalue = '0;
        if (w_ready[2]) begin
            w_win_src     = SRC_MEM;
            w_win_regdest = mem_regdest;
            w_win_wbvalue = mem_wbvalue;
        end else if (w_ready[0]) begin
            w_win_src     = SRC_PIPE;
            w_win_regdest = pipe_regdest;
            w_win_wbvalue = pipe_wbvalue;
        end else if (w_ready[1]) begin
            w_win_src     = SRC_MDU;
            w_win_regdest = mdu_regdest;
            w_win_wbvalue = mdu_wbvalue;
        end
    end

    // Writes to r0 are consumed but never reach the register file.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_regdest  <= '0;
            out_writereg <= 1'b0;
            out_wbvalue  <= '0;
            out_src      <= SRC_NONE;
        end else if (w_grant) begin
            out_regdest  <= w_win_regdest;
            out_writereg <= (w_win_regdest != '0);
            out_wbvalue  <= w_win_wbvalue;
            out_src      <= w_win_src;
        end else begin
            out_writereg <= 1'b0;
            out_src      <= SRC_NONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_port_arbiter
//  Purpose  : Directed self-checking bench for wb_port_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    logic        clock;
    logic        reset;
    logic        pipe_valid, pipe_ready;
    logic [4:0]  pipe_regdest;
    logic [31:0] pipe_wbvalue;
    logic        mdu_valid, mdu_ready;
    logic [4:0]  mdu_regdest;
    logic [31:0] mdu_wbvalue;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_regdest;
    logic [31:0] mem_wbvalue;
    logic [4:0]  out_regdest;
    logic        out_writereg;
    logic [31:0] out_wbvalue;
    logic [1:0]  out_src;

    int n_checks = 0;
    int n_fail   = 0;

    wb_port_arbiter #(
        .DATA_W       (32),
        .REG_W        (5),
        .STARVE_LIMIT (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pipe_valid   (pipe_valid),
        .pipe_ready   (pipe_ready),
        .pipe_regdest (pipe_regdest),
        .pipe_wbvalue (pipe_wbvalue),
        .mdu_valid    (mdu_valid),
        .mdu_ready    (mdu_ready),
        .mdu_regdest  (mdu_regdest),
        .mdu_wbvalue  (mdu_wbvalue),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_regdest  (mem_regdest),
        .mem_wbvalue  (mem_wbvalue),
        .out_regdest  (out_regdest),
        .out_writereg (out_writereg),
        .out_wbvalue  (out_wbvalue),
        .out_src      (out_src)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- reset held with every requester valid ----------
        reset        = 1'b0;
        pipe_valid   = 1'b1; pipe_regdest = 5'd1; pipe_wbvalue = 32'h11;
        mdu_valid    = 1'b1; mdu_regdest  = 5'd2; mdu_wbvalue  = 32'h22;
        mem_valid    = 1'b1; mem_regdest  = 5'd3; mem_wbvalue  = 32'h33;
        tick();
        tick();
        check("rst_pipe_ready", 64'(pipe_ready), 64'd0);
        check("rst_mdu_ready",  64'(mdu_ready),  64'd0);
        check("rst_mem_ready",  64'(mem_ready),  64'd0);
        check("rst_writereg",   64'(out_writereg), 64'd0);
        check("rst_src",        64'(out_src),    64'd0);
        check("rst_regdest",    64'(out_regdest), 64'd0);
        check("rst_wbvalue",    64'(out_wbvalue), 64'd0);

        reset = 1'b1;
        #1;
        check("rel_mem_ready",  64'(mem_ready),  64'd1);
        check("rel_pipe_ready", 64'(pipe_ready), 64'd0);
        pipe_valid = 1'b0; mdu_valid = 1'b0; mem_valid = 1'b0;
        tick();

        // ---------------- single pipe write ------------------------------
        pipe_valid = 1'b1; pipe_regdest = 5'd7; pipe_wbvalue = 32'h1234_5678;
        #1;
        check("pipe_ready", 64'(pipe_ready), 64'd1);
        check("pipe_mem_ready", 64'(mem_ready), 64'd0);
        check("pipe_mdu_ready", 64'(mdu_ready), 64'd0);
        tick();
        pipe_valid = 1'b0;
        check("pipe_writereg", 64'(out_writereg), 64'd1);
        check("pipe_regdest",  64'(out_regdest),  64'd7);
        check("pipe_wbvalue",  64'(out_wbvalue),  64'h1234_5678);
        check("pipe_src",      64'(out_src),      64'd1);
        tick();
        // Idle cycle: enable and source drop, address and data hold.
        check("idle_writereg", 64'(out_writereg), 64'd0);
        check("idle_src",      64'(out_src),      64'd0);
        check("idle_regdest",  64'(out_regdest),  64'd7);
        check("idle_wbvalue",  64'(out_wbvalue),  64'h1234_5678);

        // ---------------- mdu starvation ---------------------------------
        // mem and mdu request from cycle 1, pipe from cycle 2, so mdu is
        // the first to reach the limit (after 4 losses, granted cycle 5).
        mem_valid = 1'b1; mem_regdest = 5'd4; mem_wbvalue = 32'hBEEF_0004;
        mdu_valid = 1'b1; mdu_regdest = 5'd3; mdu_wbvalue = 32'h0000_AAAA;
        pipe_regdest = 5'd6; pipe_wbvalue = 32'h66;
        for (int c = 1; c <= 5; c++) begin
            pipe_valid = (c >= 2);
            #1;
            if (c < 5) begin
                check("starve_mdu_wait", 64'(mdu_ready), 64'd0);
                check("starve_mem_win",  64'(mem_ready), 64'd1);
            end else begin
                check("starve_mdu_grant", 64'(mdu_ready),  64'd1);
                check("starve_mem_lose",  64'(mem_ready),  64'd0);
                check("starve_pipe_lose", 64'(pipe_ready), 64'd0);
            end
            tick();
        end
        mdu_valid = 1'b0;
        #1;
        check("starve_out_src",     64'(out_src),      64'd2);
        check("starve_out_regdest", 64'(out_regdest),  64'd3);
        check("starve_out_wbvalue", 64'(out_wbvalue),  64'h0000_AAAA);
        check("starve_out_wr",      64'(out_writereg), 64'd1);
        // pipe has now lost cycles 2..5 and is urgent over mem.
        check("starve_pipe_urgent", 64'(pipe_ready), 64'd1);
        tick();
        check("starve_pipe_src", 64'(out_src),     64'd1);
        check("starve_pipe_reg", 64'(out_regdest), 64'd6);
        pipe_valid = 1'b0;
        #1;
        check("starve_mem_back", 64'(mem_ready), 64'd1);
        tick();
        mem_valid = 1'b0;
        check("starve_mem_src", 64'(out_src), 64'd3);
        tick();

        // ---------------- write to r0 ------------------------------------
        mdu_valid = 1'b1; mdu_regdest = 5'd0; mdu_wbvalue = 32'hDEAD_0000;
        #1;
        check("r0_mdu_ready", 64'(mdu_ready), 64'd1);
        tick();
        mdu_valid = 1'b0;
        check("r0_writereg", 64'(out_writereg), 64'd0);
        check("r0_src",      64'(out_src),      64'd2);
        check("r0_wbvalue",  64'(out_wbvalue),  64'hDEAD_0000);
        tick();

        // ---------------- pipe and mdu urgent, mem not --------------------
        mem_valid  = 1'b1; mem_regdest  = 5'd10; mem_wbvalue  = 32'hA;
        pipe_valid = 1'b1; pipe_regdest = 5'd11; pipe_wbvalue = 32'hB;
        mdu_valid  = 1'b1; mdu_regdest  = 5'd12; mdu_wbvalue  = 32'hC;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check("urg_build_mem", 64'(mem_ready), 64'd1);
            tick();
        end
        #1;
        check("urg_pipe_first", 64'(pipe_ready), 64'd1);
        check("urg_mdu_wait",   64'(mdu_ready),  64'd0);
        check("urg_mem_wait",   64'(mem_ready),  64'd0);
        tick();
        pipe_valid = 1'b0;
        check("urg_pipe_src", 64'(out_src), 64'd1);
        #1;
        check("urg_mdu_second", 64'(mdu_ready), 64'd1);
        tick();
        mdu_valid = 1'b0;
        check("urg_mdu_src", 64'(out_src), 64'd2);
        #1;
        check("urg_mem_third", 64'(mem_ready), 64'd1);
        tick();
        mem_valid = 1'b0;
        check("urg_mem_src", 64'(out_src), 64'd3);
        tick();

        // ---------------- reset mid-operation -----------------------------
        // Saturate pipe and mdu behind mem, then reset with all pending.
        mem_valid  = 1'b1; mem_regdest  = 5'd9; mem_wbvalue  = 32'h9999_0009;
        pipe_valid = 1'b1; pipe_regdest = 5'd1; pipe_wbvalue = 32'h1;
        mdu_valid  = 1'b1; mdu_regdest  = 5'd2; mdu_wbvalue  = 32'h2;
        for (int c = 1; c <= 4; c++) tick();
        check("mid_pre_src",   64'(out_src),    64'd3);
        check("mid_pre_pipe",  64'(pipe_ready), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check("mid_async_src",     64'(out_src),      64'd0);
        check("mid_async_wr",      64'(out_writereg), 64'd0);
        check("mid_async_regdest", 64'(out_regdest),  64'd0);
        check("mid_async_wbvalue", 64'(out_wbvalue),  64'd0);
        check("mid_async_pready",  64'(pipe_ready),   64'd0);
        check("mid_async_mready",  64'(mem_ready),    64'd0);
        tick();
        reset = 1'b1;
        #1;
        // Cleared counters: mem wins on base priority, nobody urgent.
        check("mid_rel_mem",  64'(mem_ready),  64'd1);
        check("mid_rel_pipe", 64'(pipe_ready), 64'd0);
        check("mid_rel_mdu",  64'(mdu_ready),  64'd0);
        tick();
        check("mid_rel_src",     64'(out_src),     64'd3);
        check("mid_rel_regdest", 64'(out_regdest), 64'd9);
        mem_valid = 1'b0; pipe_valid = 1'b0; mdu_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
